// File: rtl/ifu_pc_if.sv
// Fetch-side bundle between the PC unit and its controller/datapath.
// The slave side is the PC unit; the master side supplies control and targets.
interface ifu_pc_if;
   logic        en;
   logic [1:0]  npc_sel;
   logic        br_taken;
   logic [15:0] imm16;
   logic [25:0] imm26;
   logic [31:0] ra;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fault;
   logic [31:0] fault_pc;
   logic [31:0] fetch_cnt;

   modport master (
      output en, npc_sel, br_taken, imm16, imm26, ra,
      input  pc, pc_plus4, fault, fault_pc, fetch_cnt
   );

   modport slave (
      input  en, npc_sel, br_taken, imm16, imm26, ra,
      output pc, pc_plus4, fault, fault_pc, fetch_cnt
   );
endinterface

// File: rtl/ifu_pc.sv
// Instruction-fetch program counter for the single-cycle MIPS datapath.
// Computes next-PC (sequential/branch/jump/jr), checks it against the
// instruction-memory window and latches a sticky fault on illegal targets.
module ifu_pc #(
   parameter logic [31:0] PC_BASE  = 32'h0000_3000,
   parameter int unsigned IM_WORDS = 1024
) (
   input logic     clk,
   input logic     reset,
   ifu_pc_if.slave bus
);

   typedef enum logic {
      RUN,
      FAULT
   } state_t;

   // 33-bit bounds so PC_BASE + 4*IM_WORDS cannot overflow
   localparam logic [32:0] LO_BOUND = {1'b0, PC_BASE};
   localparam logic [32:0] HI_BOUND = {1'b0, PC_BASE} + (33'(IM_WORDS) << 2);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        fault_q, fault_d;
   logic [31:0] fault_pc_q, fault_pc_d;
   logic [31:0] fetch_cnt_q, fetch_cnt_d;

   logic [31:0] pc_plus4;
   logic [31:0] br_off;
   logic [31:0] npc;
   logic        npc_legal;

   // Candidate next-PC and its legality check
   always_comb begin
      pc_plus4 = pc_q + 32'd4;
      br_off   = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
      npc      = pc_plus4;
      unique case (bus.npc_sel)
         2'b00: npc = pc_plus4;
         2'b01: npc = bus.br_taken ? (pc_plus4 + br_off) : pc_plus4;
         2'b10: npc = {pc_plus4[31:28], bus.imm26, 2'b00};
         2'b11: npc = bus.ra;
         default: npc = pc_plus4;
      endcase
      npc_legal = (npc[1:0] == 2'b00) &&
                  ({1'b0, npc} >= LO_BOUND) &&
                  ({1'b0, npc} <  HI_BOUND);
   end

   // Next-state: advance on legal target, trap on illegal, freeze in FAULT
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      fault_d     = fault_q;
      fault_pc_d  = fault_pc_q;
      fetch_cnt_d = fetch_cnt_q;
      unique case (state_q)
         RUN: begin
            if (bus.en) begin
               if (npc_legal) begin
                  pc_d        = npc;
                  fetch_cnt_d = fetch_cnt_q + 32'd1;
               end else begin
                  fault_d    = 1'b1;
                  fault_pc_d = npc;
                  state_d    = FAULT;
               end
            end
         end
         FAULT: begin
            // only reset leaves this state
         end
         default: state_d = RUN;
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= RUN;
         pc_q        <= PC_BASE;
         fault_q     <= 1'b0;
         fault_pc_q  <= '0;
         fetch_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         fault_q     <= fault_d;
         fault_pc_q  <= fault_pc_d;
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   assign bus.pc        = pc_q;
   assign bus.pc_plus4  = pc_plus4;
   assign bus.fault     = fault_q;
   assign bus.fault_pc  = fault_pc_q;
   assign bus.fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_ifu_pc.sv
// Scoreboard bench for ifu_pc: directed walk-through plus randomized traffic,
// expected outputs from an arithmetic reference model pushed into a queue.
module tb_ifu_pc;

   localparam logic [31:0] BASE  = 32'h0000_3000;
   localparam int unsigned WORDS = 1024;

   logic clk;
   logic reset;

   ifu_pc_if bus ();

   ifu_pc #(.PC_BASE(BASE), .IM_WORDS(WORDS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] pc4;
      logic        flt;
      logic [31:0] fpc;
      logic [31:0] cnt;
      string       tag;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // reference model state
   logic [31:0] m_pc;
   logic        m_fault;
   logic [31:0] m_fpc;
   logic [31:0] m_cnt;

   function automatic void check(string name, logic [31:0] got, logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endfunction

   // monitor: every cycle with a pending expectation, compare after the edge
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check({e.tag, ".pc"},        bus.pc,               e.pc);
         check({e.tag, ".pc_plus4"},  bus.pc_plus4,         e.pc4);
         check({e.tag, ".fault"},     {31'd0, bus.fault},   {31'd0, e.flt});
         check({e.tag, ".fault_pc"},  bus.fault_pc,         e.fpc);
         check({e.tag, ".fetch_cnt"}, bus.fetch_cnt,        e.cnt);
      end
   end

   // one cycle of stimulus; model update and expectation push
   task automatic step(input string tag, input logic rst_n, input logic en,
                       input logic [1:0] sel, input logic bt,
                       input logic [15:0] i16, input logic [25:0] i26,
                       input logic [31:0] r);
      longint      tgt;
      logic [31:0] npc;
      exp_t        e;
      @(negedge clk);
      reset        = rst_n;
      bus.en       = en;
      bus.npc_sel  = sel;
      bus.br_taken = bt;
      bus.imm16    = i16;
      bus.imm26    = i26;
      bus.ra       = r;
      if (!rst_n) begin
         m_pc = BASE; m_fault = 1'b0; m_fpc = '0; m_cnt = '0;
      end else if (!m_fault && en) begin
         case (sel)
            2'b01:   tgt = bt ? (longint'(m_pc) + 4 + 4 * longint'($signed(i16))) : longint'(m_pc) + 4;
            2'b10:   tgt = longint'((m_pc + 32'd4) & 32'hF000_0000) + 4 * longint'(i26);
            2'b11:   tgt = longint'(r);
            default: tgt = longint'(m_pc) + 4;
         endcase
         npc = tgt[31:0];
         if ((npc % 4 == 0) && (npc >= BASE) && (longint'(npc) < longint'(BASE) + 4 * WORDS)) begin
            m_pc  = npc;
            m_cnt = m_cnt + 1;
         end else begin
            m_fault = 1'b1;
            m_fpc   = npc;
         end
      end
      e.pc = m_pc; e.pc4 = m_pc + 32'd4; e.flt = m_fault; e.fpc = m_fpc; e.cnt = m_cnt; e.tag = tag;
      exp_q.push_back(e);
   endtask

   task automatic do_reset(input string tag);
      step(tag, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0, '0);
   endtask

   task automatic seq(input string tag);
      step(tag, 1'b1, 1'b1, 2'b00, 1'b0, '0, '0, '0);
   endtask

   task automatic jump_to(input string tag, input logic [31:0] a);
      step(tag, 1'b1, 1'b1, 2'b10, 1'b0, '0, a[27:2], '0);
   endtask

   initial begin
      logic [31:0] r;
      logic [15:0] i16;
      logic [1:0]  sel;
      int          drained;
      reset = 1'b0;
      bus.en = 1'b0; bus.npc_sel = 2'b00; bus.br_taken = 1'b0;
      bus.imm16 = '0; bus.imm26 = '0; bus.ra = '0;
      m_pc = BASE; m_fault = 1'b0; m_fpc = '0; m_cnt = '0;

      // reset and 20 sequential fetches
      do_reset("reset");
      for (int i = 0; i < 20; i++) seq("seq");

      // branch taken / not taken from 0x3010
      jump_to("j3010", 32'h3010);
      step("br_taken", 1'b1, 1'b1, 2'b01, 1'b1, 16'hFFFC, '0, '0);
      jump_to("j3010b", 32'h3010);
      step("br_not", 1'b1, 1'b1, 2'b01, 1'b0, 16'hFFFC, '0, '0);

      // jump then out-of-range jr, then frozen
      jump_to("j3008", 32'h3008);
      step("j3500", 1'b1, 1'b1, 2'b10, 1'b0, '0, 26'h0000D40, '0);
      step("jr_oor", 1'b1, 1'b1, 2'b11, 1'b0, '0, '0, 32'h0010_8000);
      for (int i = 0; i < 3; i++) seq("frozen");
      step("frozen_jr", 1'b1, 1'b1, 2'b11, 1'b0, '0, '0, 32'h3100);

      // stalled misaligned jr is not evaluated until en rises
      do_reset("reset2");
      for (int i = 0; i < 5; i++) step("stall", 1'b1, 1'b0, 2'b11, 1'b1, '0, '0, 32'h3002);
      step("jr_mis", 1'b1, 1'b1, 2'b11, 1'b0, '0, '0, 32'h3002);

      // last word, then sequential overflow of the window; jump to base legal
      do_reset("reset3");
      jump_to("jbase", 32'h3000);
      jump_to("j3ffc", 32'h3FFC);
      seq("seq_end");
      step("reset_in_fault", 1'b0, 1'b1, 2'b00, 1'b0, '0, '0, '0);
      seq("after_reset");

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < (m_fault ? 25 : 2)) begin
            step("rnd_rst", 1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0, '0, '0, '0);
         end else begin
            sel = 2'($urandom_range(0, 3));
            i16 = 16'($urandom_range(0, 80)) - 16'd40;
            case ($urandom_range(0, 9))
               0:       r = $urandom();
               1:       r = BASE + 32'($urandom_range(0, 4 * WORDS - 1));
               default: r = BASE + (32'($urandom_range(0, WORDS - 1)) << 2);
            endcase
            step("rnd", 1'b1, ($urandom_range(0, 9) < 8), sel, 1'($urandom_range(0, 1)),
                 i16, (sel == 2'b10 && $urandom_range(0, 7) == 0) ? 26'($urandom()) : 26'(r >> 2), r);
         end
      end

      // bounded drain of outstanding expectations
      drained = 0;
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain got=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ifu_pc.md
# ifu_pc

Instruction-fetch program-counter unit for the single-cycle MIPS datapath. Holds the architectural PC that addresses the instruction memory, computes next-PC for sequential, branch, jump and jump-register flow, and raises a sticky fetch fault on misaligned or out-of-range targets. It sits directly upstream of IM: `pc` drives IM's `PC` input, and `pc_plus4` feeds the jal link path.

## Interface

Parameters:
- `PC_BASE`, 32'h0000_3000, reset PC and lowest legal fetch address
- `IM_WORDS`, 1024, number of instruction words; legal range is `PC_BASE` to `PC_BASE + 4*IM_WORDS - 4`

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-low reset (0 = reset)
- `en`  in  1  1 = advance PC this cycle; 0 = stall and hold all state
- `npc_sel`  in  2  00 sequential, 01 branch, 10 jump (j/jal), 11 register (jr)
- `br_taken`  in  1  branch condition from the comparator; used only when `npc_sel`=01
- `imm16`  in  16  branch offset, in words, signed
- `imm26`  in  26  jump index
- `ra`  in  32  jr target from the register file
- `pc`  out  32  current PC, registered, to IM
- `pc_plus4`  out  32  `pc + 4`, combinational from `pc`
- `fault`  out  1  sticky fetch-fault flag
- `fault_pc`  out  32  offending target captured at fault entry
- `fetch_cnt`  out  32  number of accepted PC updates since reset

## Operation

- Candidate next-PC (`npc`), all arithmetic modulo 2^32:
  - 00, or 01 with `br_taken`=0: `pc + 4`
  - 01 with `br_taken`=1: `pc + 4 + (sign_extend(imm16) << 2)`
  - 10: `{pc_plus4[31:28], imm26, 2'b00}`
  - 11: `ra`
- Legality: `npc[1:0]` is 00 and `PC_BASE <= npc < PC_BASE + 4*IM_WORDS`. Both comparisons are unsigned, 33-bit, so the upper bound does not overflow.
- States: RUN and FAULT.
  - RUN with `en`=1 and `npc` legal: `pc <= npc`, `fetch_cnt <= fetch_cnt + 1`.
  - RUN with `en`=1 and `npc` illegal: `pc` holds, `fault <= 1`, `fault_pc <= npc`, go to FAULT. `fetch_cnt` does not increment.
  - RUN with `en`=0: nothing changes. `npc` is not evaluated for faults.
  - FAULT: all inputs except `reset` are ignored. `pc`, `fault_pc` and `fetch_cnt` are frozen. Only reset leaves FAULT.
- Boundaries:
  - Sequential step from the last legal word (`PC_BASE + 4*IM_WORDS - 4`) faults. There is no wrap to `PC_BASE`.
  - A branch or jump to exactly `PC_BASE` is legal.
  - A jr to a misaligned address inside the range faults.
  - `fetch_cnt` wraps 32'hFFFF_FFFF to 0 without a fault.
  - `br_taken` is a don't-care for `npc_sel` values other than 01.

## Timing

- Reset (sampled `reset`=0 at a rising edge):
  - `pc` = `PC_BASE`
  - `fault` = 0
  - `fault_pc` = 0
  - `fetch_cnt` = 0
  - state = RUN
- Reset has priority over `en` and over the FAULT state. Asserting reset in the middle of a fault clears it on the same edge.
- PC update latency is one cycle. `npc` is computed from the inputs present before edge N and becomes visible on `pc` after edge N.
- `pc_plus4` settles combinationally within the cycle that `pc` changes.
- `fault` and `fault_pc` assert after the edge that detects the illegal target. On that same edge `pc` still shows the last legal address.
- No handshake with IM: IM is combinational, so `pc` is the fetch address for the whole cycle.

## Test plan

- Reset then 20 cycles with `en`=1, `npc_sel`=00: `pc` steps 0x3000, 0x3004, … 0x3050; `fetch_cnt`=20; `fault`=0.
- At `pc`=0x3010, `npc_sel`=01, `imm16`=16'hFFFC, `br_taken`=1 -> `pc`=0x3004. Repeat with `br_taken`=0 -> `pc`=0x3014.
- At `pc`=0x3008:
  - `npc_sel`=10, `imm26`=26'h0000D40 -> `pc`=0x3500.
  - Then `npc_sel`=11, `ra`=0x0010_8000 -> `fault`=1, `fault_pc`=0x0010_8000, `pc` stays 0x3500.
  - Further `en`=1 cycles change nothing.
- Hold `en`=0 for 5 cycles with `npc_sel`=11 and `ra`=0x3002: `pc` and `fetch_cnt` unchanged, `fault`=0. Raise `en` -> `fault`=1, `fault_pc`=0x3002.
- Jump to 0x3FFC, then one sequential step -> `fault`=1, `fault_pc`=0x4000, `pc`=0x3FFC.
- While in FAULT, assert `reset`=0 for one edge with `en`=1 -> `pc`=0x3000, `fault`=0, `fault_pc`=0, `fetch_cnt`=0. Next edge sequential -> `pc`=0x3004.
